// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder: opcodes, FSM states and
// instruction field helpers.
package instr_feeder_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_IMM   = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  function automatic logic [2:0] f_opcode(input logic [8:0] ir);
    return ir[8:6];
  endfunction

  function automatic logic [2:0] f_rx(input logic [8:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [2:0] f_ry(input logic [8:0] ir);
    return ir[2:0];
  endfunction

  // Only mvi carries a trailing immediate word; 1xx opcodes behave like mv.
  function automatic logic f_has_imm(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MVI:                 r = 1'b1;
      OP_MV, OP_ADD, OP_SUB:  r = 1'b0;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program store: one write port, one synchronous read port (data one cycle
// after the address). Contents are deliberately not reset.
module instr_feeder_prog_mem #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/instr_feeder.sv
// Feeds a stored program to the processor over Run/DIN/Done, one instruction
// per issue, appending the immediate for mvi and waiting for Done in between.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_Reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_start,
  input  logic [AW:0]   i_len,
  input  logic          i_Done,
  output logic          o_Run,
  output logic [DW-1:0] o_Din,
  output logic          o_busy,
  output logic          o_halt,
  output logic          o_error,
  output logic [AW:0]   o_pc,
  output logic [7:0]    o_instr_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [AW:0]     r_pc;
  logic [AW:0]     r_len;
  logic [7:0]      r_count;
  logic [TW-1:0]   r_timer;
  logic            r_halt;
  logic            r_error;

  logic [DW-1:0]   w_rd_data;
  logic [AW-1:0]   w_rd_addr;
  logic [AW:0]     w_pc_p1;
  logic            w_is_mvi;
  logic            w_wr_en;

  assign w_pc_p1   = r_pc + (AW+1)'(1);
  // ISSUE already looks ahead to pc+1 so the immediate is ready in IMM.
  assign w_rd_addr = (r_state == ST_ISSUE) ? w_pc_p1[AW-1:0] : r_pc[AW-1:0];
  assign w_is_mvi  = f_has_imm(f_opcode(w_rd_data[8:0]));
  assign w_wr_en   = i_wr_en && (r_state == ST_IDLE);

  instr_feeder_prog_mem #(
    .DW(DW),
    .AW(AW)
  ) u_prog_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_halt  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              r_halt <= 1'b1;
            end else begin
              r_halt  <= 1'b0;
              r_error <= 1'b0;
              r_pc    <= '0;
              r_count <= '0;
              r_len   <= i_len;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          r_timer <= '0;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_is_mvi) begin
            if (w_pc_p1 >= r_len) begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_IMM;
            end
          end else begin
            r_pc    <= w_pc_p1;
            r_state <= ST_WAIT;
          end
        end
        ST_IMM: begin
          r_pc    <= r_pc + (AW+1)'(2);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_Done) begin
            r_count <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
            r_timer <= '0;
            if (r_pc >= r_len) begin
              r_halt  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_FETCH;
            end
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Run         = (r_state == ST_ISSUE);
  assign o_Din         = (r_state == ST_ISSUE || r_state == ST_IMM) ? w_rd_data : '0;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_halt        = r_halt;
  assign o_error       = r_error;
  assign o_pc          = r_pc;
  assign o_instr_count = r_count;

endmodule
